// File: rtl/pll_reset_seq.sv
// PLL reset pulse, lock qualification with timeout/retry, then staged release of domain resets.
// All outputs registered. Define PLL_RESET_SEQ_LOCK_LOSS_COUNT_EN to add the saturating lock_loss_cnt output.
module pll_reset_seq #(
  parameter int NUM_RST            = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RELEASE_GAP        = 16,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int PLL_RST_CYCLES     = 32,
  parameter int CNT_W              = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic [NUM_RST-1:0] rst_out,
  output logic               ready,
  output logic [1:0]         state
`ifdef PLL_RESET_SEQ_LOCK_LOSS_COUNT_EN
  ,
  output logic [CNT_W-1:0]   lock_loss_cnt
`endif
);

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int REL_LEN = RELEASE_GAP * (NUM_RST - 1);
  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int CYC_MAX = (MAX_A > REL_LEN) ? MAX_A : REL_LEN;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int STB_W   = $clog2(LOCK_STABLE_CYCLES + 1);

  localparam logic [CYC_W-1:0] PRST_LAST = CYC_W'(PLL_RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] TMO_LAST  = CYC_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST  = STB_W'(LOCK_STABLE_CYCLES - 1);

  logic [1:0]         sync_q;
  logic               lock_s;
  state_e             state_q, state_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [STB_W-1:0]   stb_q, stb_d;
  logic               pll_rst_q, pll_rst_d;
  logic [NUM_RST-1:0] rst_out_q, rst_out_d;
  logic               ready_q, ready_d;

  assign lock_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      state_q   <= PLL_RESET;
      cyc_q     <= '0;
      stb_q     <= '0;
      pll_rst_q <= 1'b1;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], pll_locked};
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      pll_rst_q <= pll_rst_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
    end
  end

  // cyc_q counts dwell in the current state; it restarts on every state change.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q + CYC_W'(1);
    stb_d     = '0;
    rst_out_d = '1;
    unique case (state_q)
      PLL_RESET: begin
        if (cyc_q == PRST_LAST) begin
          state_d = WAIT_LOCK;
          cyc_d   = '0;
        end
      end
      WAIT_LOCK: begin
        stb_d = lock_s ? stb_q + STB_W'(1) : '0;
        // Release takes priority over a coincident timeout.
        if (lock_s && (stb_q == STB_LAST)) begin
          state_d      = RELEASE;
          cyc_d        = '0;
          rst_out_d[0] = 1'b0;
        end else if (cyc_q == TMO_LAST) begin
          state_d = PLL_RESET;
          cyc_d   = '0;
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_d = PLL_RESET;
          cyc_d   = '0;
        end else begin
          rst_out_d = rst_out_q;
          for (int i = 1; i < NUM_RST; i++) begin
            if (int'(cyc_q) + 1 >= RELEASE_GAP * i) rst_out_d[i] = 1'b0;
          end
          if (int'(cyc_q) + 1 >= REL_LEN) begin
            state_d = RUN;
            cyc_d   = '0;
          end
        end
      end
      RUN: begin
        cyc_d = '0;
        if (!lock_s) begin
          state_d = PLL_RESET;
        end else begin
          rst_out_d = rst_out_q;
        end
      end
    endcase
    pll_rst_d = (state_d == PLL_RESET);
    ready_d   = ((state_d == RELEASE) || (state_d == RUN)) && (rst_out_d == '0);
  end

  assign pll_rst = pll_rst_q;
  assign rst_out = rst_out_q;
  assign ready   = ready_q;
  assign state   = state_q;

`ifdef PLL_RESET_SEQ_LOCK_LOSS_COUNT_EN
  logic [CNT_W-1:0] llc_q;
  logic             loss_ev;

  assign loss_ev = !lock_s && ((state_q == RELEASE) || (state_q == RUN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      llc_q <= '0;
    end else if (loss_ev && (llc_q != '1)) begin
      llc_q <= llc_q + CNT_W'(1);
    end
  end

  assign lock_loss_cnt = llc_q;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq: expected output transitions (cycle, value) are queued as
// stimulus is planned and matched against every observed change of {state, pll_rst, rst_out, ready}.
module tb_pll_reset_seq;

  logic       clk;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic [2:0] rst_out;
  logic       ready;
  logic [1:0] state;
`ifdef PLL_RESET_SEQ_LOCK_LOSS_COUNT_EN
  logic [1:0] lock_loss_cnt;
`endif

  pll_reset_seq #(
    .NUM_RST(3), .LOCK_STABLE_CYCLES(8), .RELEASE_GAP(4),
    .LOCK_TIMEOUT(64), .PLL_RST_CYCLES(4), .CNT_W(2)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .rst_out(rst_out), .ready(ready), .state(state)
`ifdef PLL_RESET_SEQ_LOCK_LOSS_COUNT_EN
    , .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  typedef struct {
    int         cyc;
    logic [6:0] sig;
  } ev_t;

  ev_t        exp_q[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         cyc   = 0;
  bit         mon_en = 1'b0;
  logic [6:0] prev_sig;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, act, act, exp, exp, cyc);
    end
  endtask

  function automatic logic [6:0] mk(input logic [1:0] st, input logic p, input logic [2:0] ro, input logic r);
    return {st, p, ro, r};
  endfunction

  function automatic logic [6:0] cur_sig();
    return {state, pll_rst, rst_out, ready};
  endfunction

  task automatic push(input int c, input logic [6:0] s);
    ev_t e;
    e.cyc = c;
    e.sig = s;
    exp_q.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sampled mid-cycle: each output change must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [6:0] s;
      s = cur_sig();
      if (s !== prev_sig) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_change", int'(s), int'(prev_sig));
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("evt_cycle", cyc, e.cyc);
          chk("evt_value", int'(s), int'(e.sig));
        end
        prev_sig = s;
      end
    end
  end

  // From PLL_RESET entered at edge p (lock low), model a PLL that locks as its reset drops.
  task automatic seq_to_run(input int p);
    push(p + 4,  mk(2'd1, 1'b0, 3'b111, 1'b0));
    push(p + 14, mk(2'd2, 1'b0, 3'b110, 1'b0));
    push(p + 18, mk(2'd2, 1'b0, 3'b100, 1'b0));
    push(p + 22, mk(2'd3, 1'b0, 3'b000, 1'b1));
    wait_to(p + 4);
    pll_locked = 1'b1;
    wait_to(p + 24);
  endtask

  initial begin
    int p;
    int w;
    rst        = 1'b0;
    pll_locked = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("reset_value", int'(cur_sig()), int'(mk(2'd0, 1'b1, 3'b111, 1'b0)));
`ifdef PLL_RESET_SEQ_LOCK_LOSS_COUNT_EN
    chk("reset_llc", int'(lock_loss_cnt), 0);
`endif
    prev_sig = mk(2'd0, 1'b1, 3'b111, 1'b0);
    mon_en   = 1'b1;
    wait_to(2);
    rst = 1'b0;
    p   = 2;

    // Power-up sequence to RUN.
    seq_to_run(p);

    // Lock loss in RUN: two sync edges plus one register edge.
    p = cyc;
    push(p + 3, mk(2'd0, 1'b1, 3'b111, 1'b0));
    push(p + 7, mk(2'd1, 1'b0, 3'b111, 1'b0));
    pll_locked = 1'b0;
    wait_to(p + 4);
`ifdef PLL_RESET_SEQ_LOCK_LOSS_COUNT_EN
    chk("llc_first_loss", int'(lock_loss_cnt), 1);
`endif

    // No lock: timeout retries every 4 + 64 cycles.
    push(p + 71,  mk(2'd0, 1'b1, 3'b111, 1'b0));
    push(p + 75,  mk(2'd1, 1'b0, 3'b111, 1'b0));
    push(p + 139, mk(2'd0, 1'b1, 3'b111, 1'b0));
    push(p + 143, mk(2'd1, 1'b0, 3'b111, 1'b0));
    wait_to(p + 143);
    chk("rst_out_held", int'(rst_out), 3'b111);

    // One-cycle lock glitch after five stable cycles restarts qualification.
    w = cyc;
    push(w + 16, mk(2'd2, 1'b0, 3'b110, 1'b0));
    push(w + 20, mk(2'd2, 1'b0, 3'b100, 1'b0));
    pll_locked = 1'b1;
    wait_to(w + 5);
    pll_locked = 1'b0;
    wait_to(w + 6);
    pll_locked = 1'b1;
    wait_to(w + 21);

    // Asynchronous reset in the middle of the staged release.
    push(w + 21, mk(2'd0, 1'b1, 3'b111, 1'b0));
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_value", int'(cur_sig()), int'(mk(2'd0, 1'b1, 3'b111, 1'b0)));
`ifdef PLL_RESET_SEQ_LOCK_LOSS_COUNT_EN
    chk("async_rst_llc", int'(lock_loss_cnt), 0);
`endif
    pll_locked = 1'b0;
    wait_to(w + 23);
    rst = 1'b0;
    p   = w + 23;

    // Repeated lock losses from RUN; the counter saturates at 3.
    for (int k = 1; k <= 5; k++) begin
      seq_to_run(p);
      push(p + 27, mk(2'd0, 1'b1, 3'b111, 1'b0));
      pll_locked = 1'b0;
      wait_to(p + 28);
`ifdef PLL_RESET_SEQ_LOCK_LOSS_COUNT_EN
      chk("llc_sat", int'(lock_loss_cnt), (k > 3) ? 3 : k);
`endif
      p = p + 27;
    end

    wait_to(p + 2);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
